// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file writeback scheduler.
//   XLEN_DEF / NUM_REGS_DEF : default data width and architectural register count
//   REG_ADDR_W              : register address width (fixed, 32 registers)
//   wb_src_e                : which requester owns the write port this cycle
//   clog2                   : ceiling log2, used to size the starvation counter
package rf_sched_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned REG_ADDR_W   = 5;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MEM,
    SRC_ALU
  } wb_src_e;

  // Returns at least 1 so a counter sized with it is never zero-width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r++;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Outstanding-write scoreboard.
//   clk, rst        : clock, synchronous active-high reset
//   set_en, set_rd  : mark set_rd as having a pending write
//   clr_en, clr_rd  : mark clr_rd as written back
//   busy            : bit n set while a write to xn is outstanding; bit 0 always 0
// When set and clear target the same register in one cycle, set wins: the newer
// write is still pending.
module rf_scoreboard
  import rf_sched_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_rd] = 1'b0;
    end
    // Applied after the clear so a same-register set overrides it.
    if (set_en) begin
      busy_d[set_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler between the load unit (MEM) and the ALU.
//   clk, rst                         : clock, synchronous active-high reset
//   mem_valid/mem_ready/mem_rd/mem_data : load writeback handshake
//   alu_valid/alu_ready/alu_rd/alu_data : ALU writeback handshake
//   issue_en, issue_rd               : decode issued a writer of issue_rd
//   busy                             : outstanding-write scoreboard
//   wr_en, wr_addr, wr_data          : registered reg-file write port
// MEM has priority; the ALU is force-granted after MAX_WAIT consecutive denials.
// Optional build macro WB_BYPASS_EN adds byp_valid/byp_addr/byp_data, a
// combinational copy of the write stage for decode forwarding.
module rf_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [XLEN-1:0]       wr_data
`ifdef WB_BYPASS_EN
  ,
  output logic                  byp_valid,
  output logic [REG_ADDR_W-1:0] byp_addr,
  output logic [XLEN-1:0]       byp_data
`endif
);

  localparam int unsigned CntW = clog2(MAX_WAIT + 1);

  logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                  force_grant;
  wb_src_e               src;
  logic [REG_ADDR_W-1:0] acc_rd;
  logic [XLEN-1:0]       acc_data;

  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;

  assign force_grant = (wait_cnt_q == CntW'(MAX_WAIT));

  // Arbitration: the two readies are mutually exclusive by construction.
  always_comb begin
    mem_ready = mem_valid && !(force_grant && alu_valid);
    alu_ready = alu_valid && (!mem_valid || force_grant);
    src       = SRC_NONE;
    if (mem_ready) begin
      src = SRC_MEM;
    end else if (alu_ready) begin
      src = SRC_ALU;
    end
  end

  always_comb begin
    acc_rd   = '0;
    acc_data = '0;
    case (src)
      SRC_MEM: begin
        acc_rd   = mem_rd;
        acc_data = mem_data;
      end
      SRC_ALU: begin
        acc_rd   = alu_rd;
        acc_data = alu_data;
      end
      default: ;
    endcase
  end

  // Starvation counter: counts consecutive ALU denials, saturating at MAX_WAIT.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!alu_valid || alu_ready) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CntW'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Write stage: x0 writes are accepted but never drive wr_en.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (src != SRC_NONE) begin
      wr_en_d   = (acc_rd != '0);
      wr_addr_d = acc_rd;
      wr_data_d = acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

`ifdef WB_BYPASS_EN
  assign byp_valid = wr_en_q;
  assign byp_addr  = wr_addr_q;
  assign byp_data  = wr_data_q;
`endif

  rf_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_scoreboard (
    .clk   (clk),
    .rst   (rst),
    .set_en(issue_en && (issue_rd != '0)),
    .set_rd(issue_rd),
    .clr_en(src != SRC_NONE),
    .clr_rd(acc_rd),
    .busy  (busy)
  );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed self-checking bench for rf_wb_scheduler (MAX_WAIT = 4).
// Inputs change 1 time unit after a rising edge; registered outputs are checked
// there too, combinational readies 1 unit after the inputs settle.
module tb_rf_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
`ifdef WB_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_addr;
  logic [31:0] byp_data;
`endif

  int total;
  int bad;

  rf_wb_scheduler #(
    .XLEN(32),
    .NUM_REGS(32),
    .MAX_WAIT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_rd   (alu_rd),
    .alu_data (alu_data),
    .issue_en (issue_en),
    .issue_rd (issue_rd),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
`ifdef WB_BYPASS_EN
    ,
    .byp_valid(byp_valid),
    .byp_addr (byp_addr),
    .byp_data (byp_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    issue_en  = 1'b0;
    mem_rd    = '0;
    alu_rd    = '0;
    issue_rd  = '0;
    mem_data  = '0;
    alu_data  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (wr_en !== 1'b0) begin
      bad++; $display("FAIL reset_wr_en got=%0b want=0", wr_en);
    end
    total++;
    if (busy !== 32'h0) begin
      bad++; $display("FAIL reset_busy got=%h want=00000000", busy);
    end
    total++;
    if ({mem_ready, alu_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b want=00", {mem_ready, alu_ready});
    end
    total++;
    if ({wr_addr, wr_data} !== 37'h0) begin
      bad++; $display("FAIL reset_wr_port got=%0d/%h want=0/0", wr_addr, wr_data);
    end
  endtask

  task automatic test_mem_only();
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hDEADBEEF;
    #1;
    total++;
    if ({mem_ready, alu_ready} !== 2'b10) begin
      bad++; $display("FAIL mem_only_ready got=%b want=10", {mem_ready, alu_ready});
    end
    tick();
    mem_valid = 1'b0;
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      bad++; $display("FAIL mem_only_write got=%0b/%0d/%h want=1/5/deadbeef",
                      wr_en, wr_addr, wr_data);
    end
    tick();
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      bad++; $display("FAIL mem_only_hold got=%0b/%0d/%h want=0/5/deadbeef",
                      wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_contention();
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hAAAA0010;
    alu_valid = 1'b1; alu_rd = 5'd7;  alu_data = 32'h00000077;
    for (int c = 1; c <= 6; c++) begin
      logic [1:0] exp_rdy;
      exp_rdy = (c == 5) ? 2'b01 : 2'b10;
      #1;
      total++;
      if ({mem_ready, alu_ready} !== exp_rdy) begin
        bad++; $display("FAIL contention_ready c=%0d got=%b want=%b", c,
                        {mem_ready, alu_ready}, exp_rdy);
      end
      tick();
      total++;
      if (c == 5) begin
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd7, 32'h00000077}) begin
          bad++; $display("FAIL contention_alu_write got=%0b/%0d/%h want=1/7/77",
                          wr_en, wr_addr, wr_data);
        end
      end else if ({wr_en, wr_addr} !== {1'b1, 5'd10}) begin
        bad++; $display("FAIL contention_mem_write c=%0d got=%0b/%0d want=1/10",
                        c, wr_en, wr_addr);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++; $display("FAIL x0_ready got=%0b want=1", alu_ready);
    end
    tick();
    alu_valid = 1'b0;
    total++;
    if (wr_en !== 1'b0) begin
      bad++; $display("FAIL x0_wr_en got=%0b want=0", wr_en);
    end
  endtask

  task automatic test_scoreboard();
    issue_en = 1'b1; issue_rd = 5'd3;
    tick();
    issue_en = 1'b0;
    total++;
    if (busy !== 32'h8) begin
      bad++; $display("FAIL sb_set got=%h want=00000008", busy);
    end
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
    tick();
    mem_valid = 1'b0;
    total++;
    if ({wr_en, busy} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL sb_clear got=%0b/%h want=1/00000000", wr_en, busy);
    end
    // Same-cycle issue and writeback to x3: the bit must remain set.
    issue_en = 1'b1; issue_rd = 5'd3;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h34;
    tick();
    issue_en = 1'b0; mem_valid = 1'b0;
    total++;
    if ({wr_en, busy} !== {1'b1, 32'h8}) begin
      bad++; $display("FAIL sb_set_wins got=%0b/%h want=1/00000008", wr_en, busy);
    end
    // x0 never marked busy; x31 exercises the top bit.
    issue_en = 1'b1; issue_rd = 5'd0;
    tick();
    issue_rd = 5'd31;
    tick();
    issue_en = 1'b0;
    total++;
    if (busy !== 32'h80000008) begin
      bad++; $display("FAIL sb_x0_x31 got=%h want=80000008", busy);
    end
    // Writeback to a non-busy register leaves the vector untouched apart from it.
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h12;
    tick();
    alu_valid = 1'b0;
    total++;
    if (busy !== 32'h80000008) begin
      bad++; $display("FAIL sb_clear_idle got=%h want=80000008", busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(i); alu_data = 32'hB0B0_0000 + 32'(i);
      tick();
      total++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'(i), 32'hB0B0_0000 + 32'(i)}) begin
        bad++; $display("FAIL b2b i=%0d got=%0b/%0d/%h", i, wr_en, wr_addr, wr_data);
      end
    end
    alu_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    // ALU accepted in the same cycle reset is sampled: no write afterwards.
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    rst = 1'b1;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_accept got=%0b want=1", alu_ready);
    end
    tick();
    rst = 1'b0; alu_valid = 1'b0;
    total++;
    if ({wr_en, busy} !== {1'b0, 32'h0}) begin
      bad++; $display("FAIL rst_mid_alu got=%0b/%h want=0/00000000", wr_en, busy);
    end
    // Build up three ALU denials, reset, then expect a full MAX_WAIT again.
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (wr_en !== 1'b0) begin
      bad++; $display("FAIL rst_mid_mem got=%0b want=0", wr_en);
    end
    for (int c = 1; c <= 5; c++) begin
      #1;
      total++;
      if (alu_ready !== (c == 5)) begin
        bad++; $display("FAIL rst_mid_cnt c=%0d got=%0b want=%0b", c, alu_ready, c == 5);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hCAFE0001;
    tick();
    alu_valid = 1'b0;
    total++;
    if ({wr_en, byp_valid, byp_addr, byp_data} !== {2'b11, 5'd9, 32'hCAFE0001}) begin
      bad++; $display("FAIL bypass got=%0b/%0b/%0d/%h want=1/1/9/cafe0001",
                      wr_en, byp_valid, byp_addr, byp_data);
    end
    tick();
    total++;
    if (byp_valid !== 1'b0) begin
      bad++; $display("FAIL bypass_drop got=%0b want=0", byp_valid);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_mem_only();
    test_contention();
    test_x0();
    test_scoreboard();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
